// File: rtl/spi_transformer_master.sv
// SPI mode-0 initiator: shifts WORD_W-bit words out MSB first while capturing MISO, optional multi-word CS frames.
// Latency: accept to rx_valid = CLK_DIV*(2*WORD_W+2) cycles; tx_ready returns CLK_DIV cycles after a frame-ending rx_valid.
// Backpressure: tx_ready is high only in IDLE and WAIT_NEXT; words offered while not ready are ignored.
module spi_transformer_master #(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [WORD_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int                EDGE_W    = $clog2(2 * WORD_W);
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        WAIT_NEXT,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          div_cnt_q, div_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [WORD_W-1:0]   tx_sr_q, tx_sr_d;
    logic [WORD_W-1:0]   rx_sr_q, rx_sr_d;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                last_q, last_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                tx_ready_q, tx_ready_d;
    logic                rx_valid_q, rx_valid_d;
    logic                accept;
    logic                div_wrap;

    assign accept   = tx_valid && tx_ready_q;
    assign div_wrap = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE, WAIT_NEXT: begin
                sclk_d = 1'b0;
                if (state_q == IDLE) begin
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                end
                if (accept) begin
                    tx_sr_d    = tx_data;
                    last_d     = tx_last;
                    cs_n_d     = 1'b0;
                    mosi_d     = tx_data[WORD_W-1];
                    rx_sr_d    = '0;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_wrap) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_wrap) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sr_d = {rx_sr_q[WORD_W-2:0], spi_miso};
                    end else if (edge_cnt_q != EDGE_LAST) begin
                        // Falling edge: present the next bit; the final bit is held through HOLD.
                        tx_sr_d = tx_sr_q << 1;
                        mosi_d  = tx_sr_q[WORD_W-2];
                    end
                    if (edge_cnt_q == EDGE_LAST) begin
                        edge_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_wrap) begin
                    div_cnt_d  = '0;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    if (last_q) begin
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        state_d = WAIT_NEXT;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            GAP: begin
                mosi_d = 1'b0;
                if (div_wrap) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so tx_ready stays low while reset is held.
        tx_ready_d = (state_d == IDLE) || (state_d == WAIT_NEXT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != IDLE);
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_transformer_master.sv
// Bench for spi_transformer_master: vector table plus random frames against a bit-level SPI slave model,
// with a second CLK_DIV=2 instance for the fast-clock build.
module tb_spi_transformer_master;
    localparam int D   = 4;
    localparam int W   = 16;
    localparam int LAT = D * (2 * W + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         tx_valid, tx_ready, tx_last, rx_valid, busy;
    logic [W-1:0] tx_data, rx_data;
    logic         spi_cs_n, spi_sclk, spi_mosi;
    logic         spi_miso = 1'b0;

    logic         d2_tx_valid, d2_tx_ready, d2_tx_last, d2_rx_valid, d2_busy;
    logic [W-1:0] d2_tx_data, d2_rx_data;
    logic         d2_cs_n, d2_sclk, d2_mosi;
    logic         d2_miso = 1'b1;

    spi_transformer_master #(.CLK_DIV(D), .WORD_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_transformer_master #(.CLK_DIV(2), .WORD_W(W)) dut_div2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(d2_tx_valid), .tx_ready(d2_tx_ready), .tx_data(d2_tx_data),
        .tx_last(d2_tx_last), .rx_valid(d2_rx_valid), .rx_data(d2_rx_data), .busy(d2_busy),
        .spi_cs_n(d2_cs_n), .spi_sclk(d2_sclk), .spi_mosi(d2_mosi), .spi_miso(d2_miso)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Slave model: MSB on MISO at CS fall, next bit after each SCLK fall; MOSI captured on SCLK rise.
    logic [W-1:0] slave_words [8];
    logic [W-1:0] frame_dat   [8];
    int           frame_gap   [8];
    logic [W-1:0] slave_rcv [$];
    logic [W-1:0] rx_got [$];
    int           rx_cyc [$];
    logic [W-1:0] mosi_sr = '0;
    logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_rx = 1'b0;
    int fall_cnt, frame_rises, total_rises, last_rise_cyc, period_bad, cs_rises, rx_multi;

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            fall_cnt    = 0;
            frame_rises = 0;
            spi_miso    = slave_words[0][W-1];
        end
        if (!prev_cs && spi_cs_n) cs_rises++;
        if (!spi_cs_n && !prev_sclk && spi_sclk) begin
            if ((frame_rises % W) != 0 && (cyc - last_rise_cyc) != 2 * D) period_bad++;
            last_rise_cyc = cyc;
            mosi_sr       = {mosi_sr[W-2:0], spi_mosi};
            frame_rises++;
            total_rises++;
            if ((frame_rises % W) == 0) slave_rcv.push_back(mosi_sr);
        end
        if (!spi_cs_n && prev_sclk && !spi_sclk) begin
            fall_cnt++;
            if (fall_cnt / W < 8) spi_miso = slave_words[fall_cnt / W][W - 1 - (fall_cnt % W)];
        end
        if (rx_valid) begin
            rx_got.push_back(rx_data);
            rx_cyc.push_back(cyc);
            if (prev_rx) rx_multi++;
        end
        prev_rx   = rx_valid;
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    logic d2_prev_sclk = 1'b0;
    int d2_rises, d2_ones, d2_rise_cyc, d2_prev_rise_cyc;
    always @(negedge clk) begin
        if (!d2_prev_sclk && d2_sclk) begin
            d2_rises++;
            if (d2_mosi) d2_ones++;
            d2_prev_rise_cyc = d2_rise_cyc;
            d2_rise_cyc      = cyc;
        end
        d2_prev_sclk = d2_sclk;
    end

    task automatic send_word(input logic [W-1:0] d, input logic l, output int acc);
        int k = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        acc      = cyc;
        tx_valid = 1'b0;
        tx_data  = W'($urandom);
        tx_last  = 1'($urandom_range(0, 1));
        if (k >= 1000) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input int n, input string tag);
        int acc, n0, crise0, rises0, k;
        logic lst;
        crise0 = cs_rises;
        rises0 = total_rises;
        slave_rcv.delete();
        for (int i = 0; i < n; i++) begin
            lst = (i == n - 1);
            n0  = rx_got.size();
            send_word(frame_dat[i], lst, acc);
            k = 0;
            while (rx_got.size() == n0 && k < LAT + 50) begin
                @(negedge clk); #1;
                k++;
            end
            if (rx_got.size() == n0) begin
                check({tag, "_rx_timeout"}, 32'd0, 32'd1);
                return;
            end
            check({tag, "_rx_data"}, 32'(rx_got[n0]), 32'(slave_words[i]));
            check({tag, "_latency"}, 32'(rx_cyc[n0] - acc), 32'(LAT));
            check({tag, "_ready_at_rx"}, 32'(tx_ready), 32'(!lst));
            check({tag, "_cs_at_rx"}, 32'(spi_cs_n), 32'(lst));
            check({tag, "_mosi_word"}, (slave_rcv.size() > 0) ? 32'(slave_rcv.pop_front()) : 32'hdead_beef,
                  32'(frame_dat[i]));
            if (!lst) begin
                repeat (frame_gap[i]) begin
                    @(negedge clk); #1;
                    if (!tx_ready || spi_cs_n) check({tag, "_wait_next"}, {tx_ready, spi_cs_n}, 32'b10);
                end
            end else begin
                k = 0;
                while (!tx_ready && k < 100) begin
                    @(negedge clk); #1;
                    k++;
                end
                check({tag, "_ready_again"}, 32'(cyc - acc), 32'(LAT + D));
            end
        end
        check({tag, "_cs_releases"}, 32'(cs_rises - crise0), 32'd1);
        check({tag, "_sclk_rises"}, 32'(total_rises - rises0), 32'(W * n));
    endtask

    typedef struct {
        logic [W-1:0] dat;
        logic [W-1:0] miso;
        logic         last;
        int           gap;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int acc, n, idx, k, n0;
        vecs[0] = '{16'hA55A, 16'h3CC3, 1'b1, 0};
        vecs[1] = '{16'h1234, 16'h5A5A, 1'b0, 10};
        vecs[2] = '{16'hABCD, 16'hC0DE, 1'b1, 0};
        vecs[3] = '{16'h00FF, 16'hF00F, 1'b0, 3};
        vecs[4] = '{16'h8001, 16'h7FFE, 1'b1, 0};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 0};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 0};

        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        d2_tx_valid = 1'b0; d2_tx_data = '0; d2_tx_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx", {rx_valid, 15'd0, rx_data}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(tx_ready), 32'd1);

        idx = 0;
        while (idx < 7) begin
            n = 0;
            do begin
                frame_dat[n]   = vecs[idx].dat;
                slave_words[n] = vecs[idx].miso;
                frame_gap[n]   = vecs[idx].gap;
                n++;
                idx++;
            end while (!vecs[idx-1].last && idx < 7);
            run_frame(n, "vec");
        end

        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                frame_dat[i]   = W'($urandom);
                slave_words[i] = W'($urandom);
                frame_gap[i]   = $urandom_range(0, 5);
            end
            run_frame(n, "rnd");
        end

        // Reset mid-frame after the 5th rising edge.
        n0 = rx_got.size();
        slave_words[0] = 16'h1111;
        send_word(16'hC3C3, 1'b1, acc);
        k = 0;
        while (k < 500) begin
            @(negedge clk); #1;
            if (frame_rises >= 5) break;
            k++;
        end
        check("midrst_reached_5th_edge", 32'(frame_rises), 32'd5);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {28'd0, spi_cs_n, spi_sclk, spi_mosi, tx_ready}, 32'b1000);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        #1;
        check("midrst_no_rx_valid", 32'(rx_got.size() - n0), 32'd0);
        frame_dat[0] = 16'h5EED; slave_words[0] = 16'hBEEF;
        run_frame(1, "postrst");

        // CLK_DIV=2 instance with MISO tied high.
        @(negedge clk);
        d2_tx_valid = 1'b1; d2_tx_data = 16'hFFFF; d2_tx_last = 1'b1;
        k = 0;
        while (!d2_tx_ready && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        acc = cyc;
        d2_tx_valid = 1'b0; d2_tx_data = '0;
        k = 0;
        while (!d2_rx_valid && k < 200) begin @(negedge clk); #1; k++; end
        check("div2_latency", 32'(cyc - acc), 32'd68);
        check("div2_rx_data", 32'(d2_rx_data), 32'hFFFF);
        check("div2_rises", 32'(d2_rises), 32'd16);
        check("div2_mosi_ones", 32'(d2_ones), 32'd16);
        check("div2_sclk_period", 32'(d2_rise_cyc - d2_prev_rise_cyc), 32'd4);

        repeat (10) @(negedge clk);
        check("sclk_period_violations", 32'(period_bad), 32'd0);
        check("rx_valid_multi_cycle", 32'(rx_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_transformer_master.md
Name: spi_transformer_master

Overview:
SPI mode-0 initiator (CPOL=0, CPHA=0) that drives the 64x64 transformer SPI slave from the host-side system clock domain. It accepts 16-bit words over a valid/ready handshake and shifts each word out MSB first on MOSI while capturing 16 MISO bits. Consecutive words may share one chip-select frame. All SPI outputs are generated and registered in the single system clock domain.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles; legal range 2..255; SCLK period is 2*CLK_DIV.
WORD_W, 16, bits per word; 8 or 16 only.

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  word offered
tx_ready  output  1  word accepted in any cycle where tx_valid && tx_ready
tx_data  input  WORD_W  word to send, MSB first
tx_last  input  1  sampled with tx_data; 1 = release CS after this word
rx_valid  output  1  one-cycle pulse: rx_data is valid
rx_data  output  WORD_W  MISO bits captured during the word; first bit captured is the MSB
busy  output  1  high whenever state != IDLE
spi_cs_n  output  1  chip select, active low
spi_sclk  output  1  SPI clock, idle low
spi_mosi  output  1  SPI data out
spi_miso  input  1  SPI data in

Behaviour:
- Reset (async, immediate): spi_cs_n=1, spi_sclk=0, spi_mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state=IDLE, all counters 0.
- First cycle after reset release: tx_ready=1.
- States: IDLE, SETUP, SHIFT, HOLD, WAIT_NEXT, GAP.
- IDLE: tx_ready=1, spi_cs_n=1, spi_sclk=0.
  - On accept: latch tx_data/tx_last, spi_cs_n<=0, spi_mosi<=tx_data[MSB], go to SETUP.
- SETUP: CLK_DIV cycles with spi_sclk=0, then go to SHIFT.
- SHIFT: a half-period counter runs 0..CLK_DIV-1; spi_sclk toggles when it wraps.
  - Rising edge (sclk 0->1): shift spi_miso into rx shift register LSB end (register shifts left).
  - Falling edge (sclk 1->0): spi_mosi <= next tx bit, except after the final bit.
  - After WORD_W rising and WORD_W falling edges (2*WORD_W*CLK_DIV cycles), go to HOLD.
- HOLD: CLK_DIV cycles with spi_sclk=0 and CS still asserted. On its last cycle:
  - rx_data <= shift register; rx_valid=1 for exactly one cycle.
  - If latched last=1: spi_cs_n<=1, go to GAP.
  - Else: go to WAIT_NEXT.
- WAIT_NEXT: CS held low, sclk low, tx_ready=1.
  - On accept: latch the word, set spi_mosi to its MSB, go to SETUP (CLK_DIV setup is re-applied).
  - There is no timeout; the frame stays open until the next word arrives.
- GAP: CS high for CLK_DIV cycles (minimum deselect time), then IDLE. tx_ready=0 throughout GAP.
- Latency, single-word frame: accept to rx_valid = CLK_DIV + 2*WORD_W*CLK_DIV + CLK_DIV cycles (136 at defaults). Accept to tx_ready high again = 140 cycles.
- tx_ready is 0 in SETUP, SHIFT, HOLD and GAP. tx_data changes while not ready are ignored.
- spi_mosi holds its last bit through HOLD. It is forced to 0 in IDLE and GAP.
- MISO needs no synchronizer: the slave updates MISO on the SCLK falling edge, and MISO is sampled CLK_DIV cycles later at the rising edge.
- Reset asserted mid-frame: outputs are forced to reset values immediately (CS releases asynchronously). No rx_valid is produced for the partial word.

Test Plan:
- Reset: hold rst_n=0 -> cs_n=1, sclk=0, mosi=0, tx_ready=0. Release reset -> tx_ready=1 next cycle.
- Single word: tx_data=0xA55A, tx_last=1, slave model drives 0x3CC3.
  - MOSI bits sampled on sclk rising edges read 1010010101011010.
  - 16 rising edges occur; rx_valid pulses at cycle 136 with rx_data=0x3CC3.
  - cs_n returns high and stays high >=4 cycles.
- Two-word frame: 0x1234 (last=0), then 0xABCD (last=1) offered 10 cycles after the first rx_valid.
  - cs_n stays low throughout.
  - tx_ready is high in WAIT_NEXT only.
  - Two rx_valid pulses; 32 sclk rising edges total.
- Loopback against the existing slave receiver (MOSI to slave, slave MISO back):
  - Send 0x00FF then 0x8001 in one frame.
  - Slave received_data_16 reads 0x00FF, then 0x8001.
- Reset mid-frame: assert rst_n=0 after the 5th sclk rising edge.
  - cs_n goes high in the same cycle; no rx_valid.
  - A new word after reset completes normally.
- CLK_DIV=2 build: 0xFFFF -> sclk period 4 cycles; rx_valid at cycle 68.
